reg_chan_mux: RTL and testbench

REG_CHAN_MUX -- requirements
Module: reg_chan_mux

---
 rtl/reg_chan_mux_pkg.sv | 27 ++
 rtl/reg_chan_mux_rr_arbiter.sv | 43 ++++
 rtl/reg_chan_mux.sv | 141 ++++++++++++++
 tb/tb_reg_chan_mux.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/reg_chan_mux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_chan_mux_pkg : mode encoding and channel limits for the mux   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package reg_chan_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int c_nch_min   = 2;
  localparam int c_nch_max   = 16;
  localparam int c_width_min = 1;
  localparam int c_width_max = 64;

  function automatic bit nch_legal(input int n);
    return (n >= c_nch_min) && (n <= c_nch_max) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit width_legal(input int w);
    return (w >= c_width_min) && (w <= c_width_max);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_chan_mux_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : wrap-around priority search starting after i_ptr    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arbiter
  import reg_chan_mux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SW = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [SW-1:0]  i_ptr,
  input  logic           i_en,
  output logic [NCH-1:0] o_grant,
  output logic [SW-1:0]  o_idx,
  output logic           o_any
);

  logic [SW-1:0] w_cand;
  logic          w_found;

  // NCH is a power of two, so SW-bit addition wraps modulo NCH for free;
  // the last candidate (offset NCH) is the pointer itself.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_cand = i_ptr + SW'(k);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

  assign o_any = w_found;

endmodule
`default_nettype wire

// File: rtl/reg_chan_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_chan_mux : NCH-to-1 channel mux, fixed or round-robin select, |
// | single registered output stage with valid/ready handshake.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module reg_chan_mux
  import reg_chan_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SW   = $clog2(NCH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SW-1:0]             sel,
  input  logic [NCH-1:0][WIDTH-1:0] in_data,
  input  logic [NCH-1:0]            in_valid,
  output logic [NCH-1:0]            in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SW-1:0]             out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  if (!nch_legal(NCH)) begin : g_bad_nch
    $error("reg_chan_mux: NCH must be a power of two in 2..16");
  end
  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("reg_chan_mux: WIDTH must be in 1..64");
  end

  mode_e          w_mode;
  logic           w_load;
  logic [NCH-1:0] w_fix_grant;
  logic [NCH-1:0] w_rr_grant;
  logic [SW-1:0]  w_rr_idx;
  logic           w_rr_any;
  logic [NCH-1:0] w_grant;
  logic [SW-1:0]  w_idx;
  logic           w_any;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SW-1:0]    r_out_ch;
  logic [SW-1:0]    r_ptr;

  assign w_mode = mode_e'(mode);
  assign w_load = !r_out_valid || out_ready;

  always_comb begin
    w_fix_grant      = '0;
    w_fix_grant[sel] = w_load && in_valid[sel] && (w_mode == MODE_FIXED);
  end

  rr_arbiter #(
    .NCH (NCH)
  ) u_rr_arbiter (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_load && (w_mode == MODE_RR)),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  // Grants are suppressed during reset so no channel sees a handshake.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    if (rst_n) begin
      if (w_mode == MODE_FIXED) begin
        w_grant = w_fix_grant;
        w_idx   = sel;
      end else begin
        w_grant = w_rr_any ? w_rr_grant : '0;
        w_idx   = w_rr_idx;
      end
    end
  end

  assign w_any    = |w_grant;
  assign in_ready = w_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SW'(NCH - 1);
    end else if (w_any) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[w_idx];
      r_out_ch    <= w_idx;
      r_ptr       <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

  // Snapshot of the previous cycle, used only to check stall stability.
  logic             r_chk_stall;
  logic [WIDTH-1:0] r_chk_data;
  logic [SW-1:0]    r_chk_ch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chk_stall <= 1'b0;
      r_chk_data  <= '0;
      r_chk_ch    <= '0;
    end else begin
      r_chk_stall <= r_out_valid && !out_ready;
      r_chk_data  <= r_out_data;
      r_chk_ch    <= r_out_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(in_ready))
        else $error("reg_chan_mux: in_ready not one-hot-or-zero at %0t", $time);
      assert ((in_ready & ~in_valid) == '0)
        else $error("reg_chan_mux: in_ready without in_valid at %0t", $time);
      if (r_chk_stall) begin
        assert (r_out_valid && (r_out_data == r_chk_data) && (r_out_ch == r_chk_ch))
          else $error("reg_chan_mux: held beat changed while stalled at %0t", $time);
      end
      if ((w_mode == MODE_FIXED) && (in_ready != '0)) begin
        assert (in_ready == (NCH'(1) << sel))
          else $error("reg_chan_mux: fixed-mode grant differs from sel at %0t", $time);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_chan_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_chan_mux : directed + random stimulus vs behavioural model |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_reg_chan_mux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SW    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      mode;
  logic [SW-1:0]             sel;
  logic [NCH-1:0][WIDTH-1:0] in_data;
  logic [NCH-1:0]            in_valid;
  logic [NCH-1:0]            in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SW-1:0]             out_ch;
  logic                      out_valid;
  logic                      out_ready;

  always #5 clk = ~clk;

  reg_chan_mux #(.WIDTH(WIDTH), .NCH(NCH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: last beat on the output and the last channel served.
  bit m_valid = 1'b0;
  int m_data  = 0;
  int m_ch    = 0;
  int m_last  = NCH - 1;
  logic [NCH-1:0] obs_ready;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Channel accepted this cycle, or -1 when none.
  function automatic int ref_pick(input bit r, input bit md, input int s,
                                  input logic [NCH-1:0] v, input bit ordy);
    if (!r) return -1;
    if (m_valid && !ordy) return -1;
    if (!md) return v[s] ? s : -1;
    for (int j = 1; j <= NCH; j++) begin
      int c;
      c = (m_last + j) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input bit r, input bit md, input int s, input logic [NCH-1:0] v,
                      input logic [NCH-1:0][WIDTH-1:0] d, input bit ordy);
    int g;
    logic [NCH-1:0] exp_rdy;
    @(negedge clk);
    rst_n = r; mode = md; sel = s[SW-1:0]; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    g = ref_pick(r, md, s, v, ordy);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_ready = in_ready;
    chk_val("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (!r) begin
      m_valid = 1'b0; m_data = 0; m_ch = 0; m_last = NCH - 1;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_data = d[g]; m_ch = g; m_last = g;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    chk_val("out_valid", out_valid, m_valid);
    chk_val("out_data", out_data, m_data);
    chk_val("out_ch", out_ch, m_ch);
  endtask

  initial begin
    logic [NCH-1:0][WIDTH-1:0] d, d2, d3, dr;
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    d = {8'h44, 8'hA5, 8'h22, 8'h11};

    // Reset with all channels requesting
    step(0, 0, 0, 4'hF, d, 1);
    step(0, 0, 0, 4'hF, d, 1);
    chk_val("rst_rdy", obs_ready, 0);
    chk_val("rst_valid", out_valid, 0);
    chk_val("rst_data", out_data, 0);
    chk_val("rst_ch", out_ch, 0);

    // Fixed select of channel 2
    step(1, 0, 2, 4'hF, d, 1);
    chk_val("fix_rdy", obs_ready, 4'b0100);
    chk_val("fix_data", out_data, 8'hA5);
    chk_val("fix_ch", out_ch, 2);

    // Round-robin fairness from reset
    step(0, 1, 0, 4'hF, d, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 4'hF, d, 1);
      chk_val("rr_seq", out_ch, i % NCH);
    end

    // Skip and wrap from ptr=3
    step(1, 1, 0, 4'b0100, d, 1);
    chk_val("rr_skip", out_ch, 2);
    step(1, 1, 0, 4'b0011, d, 1);
    chk_val("rr_wrap0", out_ch, 0);
    step(1, 1, 0, 4'b0011, d, 1);
    chk_val("rr_wrap1", out_ch, 1);

    // Backpressure on a held beat
    d2 = d; d2[0] = 8'h3C;
    step(1, 0, 0, 4'b0001, d2, 1);
    chk_val("bp_load", out_data, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 4'hF, d2, 0);
      chk_val("bp_rdy", obs_ready, 0);
      chk_val("bp_hold", out_data, 8'h3C);
    end
    d3 = d; d3[0] = 8'h77;
    step(1, 0, 0, 4'b0001, d3, 1);
    chk_val("bp_release_rdy", obs_ready, 4'b0001);
    chk_val("bp_release_data", out_data, 8'h77);

    // Reset in the middle of a stall
    step(1, 1, 0, 4'hF, d, 0);
    chk_val("ms_stalled", out_valid, 1);
    step(0, 1, 0, 4'hF, d, 0);
    chk_val("ms_cleared", out_valid, 0);
    step(1, 1, 0, 4'hF, d, 1);
    chk_val("ms_first_rr", out_ch, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NCH; c++) dr[c] = 8'($urandom);
      step($urandom_range(0, 49) != 0, 1'($urandom), int'($urandom_range(0, NCH - 1)),
           4'($urandom), dr, $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
